// File: rtl/t_sync_counter.sv
// ============================================================================
// Module   : t_sync_counter
// Brief    : Modulo-N up/down counter built from T-type state bits
//            (q <= q ^ tog). Define T_COUNTER_SAT_EN for saturating mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] tog,
    output logic             tc,
    output logic             wrap
);

    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
            $error("t_sync_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_at_limit;

    assign w_at_limit = up ? (r_q == c_max) : (r_q == c_zero);

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = (din > c_max) ? c_max : din;
        end else if (en) begin
            if (w_at_limit) begin
`ifdef T_COUNTER_SAT_EN
                w_q_next = r_q;
`else
                // Wrapping to the opposite end of the range.
                w_q_next    = up ? c_zero : c_max;
                w_wrap_next = 1'b1;
`endif
            end else begin
                w_q_next = up ? (r_q + c_one) : (r_q - c_one);
            end
        end
    end

    assign tog = r_q ^ w_q_next;
    assign tc  = en & ~load & w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= c_zero;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= r_q ^ tog;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_t_sync_counter.sv
// ============================================================================
// Module   : tb_t_sync_counter
// Brief    : Self-checking bench for t_sync_counter (WIDTH=4, MODULUS=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t_sync_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] tog;
    logic             tc;
    logic             wrap;

    int n_checks = 0;
    int n_errors = 0;

    int m_q    = 0;
    int m_wrap = 0;

    t_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tog  (tog),
        .tc   (tc),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next count from the arithmetic rules of the counter.
    function automatic int model_next(input int cq, input int e, input int u,
                                      input int l, input int d);
        if (l != 0) return (d >= MODULUS) ? MODULUS - 1 : d;
        if (e == 0) return cq;
`ifdef T_COUNTER_SAT_EN
        if (u != 0) return (cq == MODULUS - 1) ? cq : cq + 1;
        return (cq == 0) ? 0 : cq - 1;
`else
        if (u != 0) return (cq + 1) % MODULUS;
        return (cq + MODULUS - 1) % MODULUS;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    = 0;
            m_wrap = 0;
        end else begin
            int nxt;
            nxt = model_next(m_q, int'(en), int'(up), int'(load), int'(din));
`ifdef T_COUNTER_SAT_EN
            m_wrap = 0;
`else
            m_wrap = (load == 1'b0 && en == 1'b1 &&
                      ((up == 1'b1 && m_q == MODULUS - 1) || (up == 1'b0 && m_q == 0))) ? 1 : 0;
`endif
            m_q = nxt;
        end
    end

    always @(negedge clk) begin
        int nxt;
        int tc_exp;
        nxt    = model_next(m_q, int'(en), int'(up), int'(load), int'(din));
        tc_exp = (en && !load && (up ? (m_q == MODULUS - 1) : (m_q == 0))) ? 1 : 0;
        check("model_q",    int'(q),    m_q);
        check("model_wrap", int'(wrap), m_wrap);
        check("model_tog",  int'(tog),  m_q ^ nxt);
        check("model_tc",   int'(tc),   tc_exp);
    end

    task automatic step(input logic e, input logic u, input logic l, input logic [WIDTH-1:0] d);
        en   = e;
        up   = u;
        load = l;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst  = 1'b1;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        din  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_q",    int'(q),    0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_tog",  int'(tog),  0);
        check("rst_tc",   int'(tc),   0);
        rst = 1'b0;

`ifndef T_COUNTER_SAT_EN
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0);
            check("up_q",    int'(q),    exp_up[i]);
            check("up_wrap", int'(wrap), (i == 9) ? 1 : 0);
            check("up_tc",   int'(tc),   (exp_up[i] == 9) ? 1 : 0);
            if (exp_up[i] == 7) check("up_tog_at7", int'(tog), 15);
        end
        step(1'b1, 1'b1, 1'b1, 4'd1);
        check("pre_down_q", int'(q), 1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("down_q0",    int'(q),    0);
        check("down_tog0",  int'(tog),  9);
        check("down_tc0",   int'(tc),   1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("down_q9",    int'(q),    9);
        check("down_wrap9", int'(wrap), 1);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("down_q8",    int'(q),    8);
        check("down_wrap8", int'(wrap), 0);
`else
        step(1'b0, 1'b1, 1'b1, 4'd8);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0);
            check("sat_up_q",    int'(q),    9);
            check("sat_up_wrap", int'(wrap), 0);
            check("sat_up_tc",   int'(tc),   1);
            check("sat_up_tog",  int'(tog),  0);
        end
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0);
            check("sat_dn_q",    int'(q),    0);
            check("sat_dn_tog",  int'(tog),  0);
            check("sat_dn_wrap", int'(wrap), 0);
        end
`endif

        // Load beats enable; out-of-range values clamp; load works with en=0.
        step(1'b1, 1'b1, 1'b1, 4'd6);
        check("load6_q",    int'(q),    6);
        check("load6_wrap", int'(wrap), 0);
        step(1'b1, 1'b1, 1'b1, 4'd13);
        check("load13_q", int'(q), 9);
        step(1'b0, 1'b1, 1'b1, 4'd2);
        check("load_noen_q", int'(q), 2);

        step(1'b0, 1'b1, 1'b1, 4'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'd0);
            check("hold_q",   int'(q),   4);
            check("hold_tog", int'(tog), 0);
            check("hold_tc",  int'(tc),  0);
        end
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("dir_q5a", int'(q), 5);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("dir_q4", int'(q), 4);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("dir_q5b", int'(q), 5);

        // Asynchronous reset between edges while q=7.
        step(1'b0, 1'b1, 1'b1, 4'd7);
        check("pre_rst_q", int'(q), 7);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q",    int'(q),    0);
        check("async_rst_wrap", int'(wrap), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_q", int'(q), 1);

        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
